// File: rtl/torrence_types.sv
//==============================================================================
// Module      : torrence_types (package)
// Description : Shared type definitions for the memory subsystem: the memory
//               operation enum carried on L1/L2 request ports, the L2 request
//               arbiter state encoding and its grant-owner encodings.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package torrence_types;

    // Operation carried on every cache/L2 request port.
    typedef enum logic [1:0] {
        LOAD       = 2'b00,
        STORE      = 2'b01,
        CLFLUSH    = 2'b10,
        MO_UNKNOWN = 2'b11
    } memory_operation_e;

    // L2 request arbiter state. ST_UNKNOWN exists so that an illegal state
    // propagates X through simulation instead of silently aliasing a legal one.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT_I = 2'b01,
        ST_GRANT_D = 2'b10,
        ST_UNKNOWN = 2'bxx
    } l2_arb_state_e;

    // grant_owner output encodings of the L2 request arbiter.
    localparam logic [1:0] GRANT_NONE   = 2'b00;
    localparam logic [1:0] GRANT_ICACHE = 2'b01;
    localparam logic [1:0] GRANT_DCACHE = 2'b10;

    // Maps an arbiter state onto the grant_owner encoding.
    function automatic logic [1:0] grant_owner_of(input l2_arb_state_e st);
        case (st)
            ST_IDLE:    grant_owner_of = GRANT_NONE;
            ST_GRANT_I: grant_owner_of = GRANT_ICACHE;
            ST_GRANT_D: grant_owner_of = GRANT_DCACHE;
            default:    grant_owner_of = 2'bxx;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/l2_request_arbiter.sv
//==============================================================================
// Module      : l2_request_arbiter
// Description : Shares the single L2 request port between the instruction
//               cache and the data cache. A cache owns the port for its whole
//               request window (multi-beat writeback/allocate/flush bursts),
//               and ownership alternates round-robin when both contend.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   i_req_valid       : icache request window (always a LOAD)
//   i_req_addr        : icache beat address
//   i_req_fulfilled   : beat-complete strobe to icache
//   d_req_valid       : dcache request window
//   d_req_type        : dcache operation (may change inside one window)
//   d_req_addr        : dcache beat address
//   d_req_wdata       : dcache store data
//   d_req_fulfilled   : beat-complete strobe to dcache
//   l2_req_valid/type/addr/wdata : request towards L2
//   l2_req_fulfilled  : beat-complete strobe from L2
//   grant_owner       : 00 none, 01 icache, 10 dcache
//   protocol_error    : sticky, L2 strobed with no active request
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module l2_request_arbiter
    import torrence_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,

    // icache side
    input  logic              i_req_valid,
    input  logic [XLEN-1:0]   i_req_addr,
    output logic              i_req_fulfilled,

    // dcache side
    input  logic              d_req_valid,
    input  memory_operation_e d_req_type,
    input  logic [XLEN-1:0]   d_req_addr,
    input  logic [XLEN-1:0]   d_req_wdata,
    output logic              d_req_fulfilled,

    // L2 side
    output logic              l2_req_valid,
    output memory_operation_e l2_req_type,
    output logic [XLEN-1:0]   l2_req_addr,
    output logic [XLEN-1:0]   l2_req_wdata,
    input  logic              l2_req_fulfilled,

    // status
    output logic [1:0]        grant_owner,
    output logic              protocol_error
);

    l2_arb_state_e state_q, state_d;

    // When set, the dcache wins a tie in ST_IDLE. Only a release moves it,
    // so a dcache writeback->allocate type change inside one window never
    // perturbs the fairness pointer.
    logic prio_d_q, prio_d_d;

    logic protocol_error_q;

    //--------------------------------------------------------------------------
    // State, priority pointer and sticky error register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            prio_d_q         <= 1'b1;
            protocol_error_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_d_q <= prio_d_d;
            // A strobe while nothing is presented to L2 means L2 and the
            // arbiter disagree about who is being served.
            if (l2_req_fulfilled && !l2_req_valid) begin
                protocol_error_q <= 1'b1;
            end
        end
    end

    assign protocol_error = protocol_error_q;

    //--------------------------------------------------------------------------
    // Next-state and priority pointer
    //--------------------------------------------------------------------------
    // A release always passes through the owner's grant state with its valid
    // low, so a requester that drops and immediately re-raises valid cannot
    // keep the port: it re-arbitrates with the pointer favouring the other.
    always_comb begin
        state_d  = state_q;
        prio_d_d = prio_d_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid && d_req_valid) begin
                    state_d = prio_d_q ? ST_GRANT_D : ST_GRANT_I;
                end else if (d_req_valid) begin
                    state_d = ST_GRANT_D;
                end else if (i_req_valid) begin
                    state_d = ST_GRANT_I;
                end
            end

            ST_GRANT_I: begin
                if (!i_req_valid) begin
                    prio_d_d = 1'b1;
                    state_d  = d_req_valid ? ST_GRANT_D : ST_IDLE;
                end
            end

            ST_GRANT_D: begin
                if (!d_req_valid) begin
                    prio_d_d = 1'b0;
                    state_d  = i_req_valid ? ST_GRANT_I : ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_UNKNOWN;
                prio_d_d = 1'bx;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath mux and fulfilled routing
    //--------------------------------------------------------------------------
    // Everything here is combinational on the current state and the owner's
    // live inputs, so the owner dropping valid drops l2_req_valid and masks
    // any strobe in that same cycle.
    always_comb begin
        l2_req_valid    = 1'b0;
        l2_req_type     = LOAD;
        l2_req_addr     = '0;
        l2_req_wdata    = '0;
        i_req_fulfilled = 1'b0;
        d_req_fulfilled = 1'b0;
        grant_owner     = grant_owner_of(state_q);

        case (state_q)
            ST_IDLE: begin
                // defaults already describe an idle port
            end

            ST_GRANT_I: begin
                l2_req_valid    = i_req_valid;
                l2_req_type     = LOAD;
                l2_req_addr     = i_req_addr;
                i_req_fulfilled = l2_req_fulfilled & i_req_valid;
            end

            ST_GRANT_D: begin
                l2_req_valid    = d_req_valid;
                l2_req_type     = d_req_type;
                l2_req_addr     = d_req_addr;
                l2_req_wdata    = d_req_wdata;
                d_req_fulfilled = l2_req_fulfilled & d_req_valid;
            end

            default: begin
                l2_req_valid    = 1'bx;
                l2_req_type     = MO_UNKNOWN;
                l2_req_addr     = 'x;
                l2_req_wdata    = 'x;
                i_req_fulfilled = 1'bx;
                d_req_fulfilled = 1'bx;
                grant_owner     = 2'bxx;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/l2_request_arbiter.md
# l2_request_arbiter

Two-requester arbiter that shares the single L2 request port between the instruction cache and the data cache. It grants the port to one cache for the entire duration of that cache's request window, covering writeback, allocate and flush bursts of many beats. It routes address, write data and the per-beat fulfilled strobe to and from the owner, and alternates priority round-robin when both caches contend. It sits between the two L1 cache controllers and the L2.

## Interface
- XLEN, 32, width of address and data words
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  icache requests L2; held high for its whole request window (always LOAD)
- i_req_addr  in  XLEN  icache beat address
- i_req_fulfilled  out  1  one-cycle beat-complete strobe to icache
- d_req_valid  in  1  dcache requests L2; held high for its whole request window
- d_req_type  in  memory_operation_e  LOAD or STORE (may change while valid stays high)
- d_req_addr  in  XLEN  dcache beat address
- d_req_wdata  in  XLEN  dcache store data
- d_req_fulfilled  out  1  one-cycle beat-complete strobe to dcache
- l2_req_valid  out  1  request to L2
- l2_req_type  out  memory_operation_e  operation to L2
- l2_req_addr  out  XLEN  address to L2
- l2_req_wdata  out  XLEN  store data to L2
- l2_req_fulfilled  in  1  L2 beat-complete strobe
- grant_owner  out  2  00 none, 01 icache, 10 dcache
- protocol_error  out  1  sticky; set on a fulfilled strobe with no active request

## Operation
- States: ST_IDLE, ST_GRANT_I, ST_GRANT_D. prio_d is a 1-bit pointer; when 1, dcache wins ties.
- ST_IDLE
  - Only one valid: go to that requester's grant state.
  - Both valid: the prio_d winner is granted.
  - Neither valid: stay in ST_IDLE.
- ST_GRANT_X with owner valid high: hold the grant. Owner type, address and wdata pass combinationally to L2; l2_req_fulfilled passes to the owner's fulfilled output only.
- ST_GRANT_X with owner valid low (release)
  - Other requester valid: go directly to its grant state.
  - Otherwise: go to ST_IDLE.
  - In both cases, prio_d is set to favour the requester not just released.
- A dcache writeback→allocate sequence keeps d_req_valid high with a type change. It is one grant and must not be split.
- Non-owner fulfilled output is always 0. i_req_type is implicitly LOAD.
- protocol_error is set when l2_req_fulfilled=1 while l2_req_valid=0. It is cleared only by reset.
- An illegal state drives all outputs and next state to X, with l2_req_type=MO_UNKNOWN.

## Timing
- Reset values: state ST_IDLE, prio_d=1, grant_owner=00, l2_req_valid=0, l2_req_type=LOAD, l2_req_addr=0, l2_req_wdata=0, i_req_fulfilled=0, d_req_fulfilled=0, protocol_error=0.
- Grant latency: a request seen in ST_IDLE in cycle N gives a grant state and l2_req_valid=1 in cycle N+1.
- l2_req_valid = (ST_GRANT_I & i_req_valid) | (ST_GRANT_D & d_req_valid), evaluated in the same cycle. The owner dropping valid drops l2_req_valid in that same cycle.
- Fulfilled routing is zero-latency combinational: owner fulfilled = l2_req_fulfilled & l2_req_valid.
- Handoff: the owner drops valid in cycle M with the other requester pending. The new owner sees l2_req_valid=1 in M+1, so there is exactly one dead cycle.
- Simultaneous release and new request from the same requester in ST_GRANT_X: release wins. That requester re-arbitrates from ST_IDLE, and prio_d favours the other requester.
- Reset asserted mid-grant: all outputs reach reset values after the reset edge. An in-flight burst is abandoned with no completion strobe.

## Structure
- memory_operation_e (LOAD, STORE, CLFLUSH, MO_UNKNOWN) comes from torrence_types.
- Add to torrence_types:
  - the arbiter state enum l2_arb_state_e (ST_IDLE=2'b00, ST_GRANT_I=2'b01, ST_GRANT_D=2'b10, ST_UNKNOWN=2'bxx);
  - the grant_owner encodings.
- Split into two always_comb blocks (next-state and datapath mux) plus a state/pointer/error register block.
- Sub-module: none. The design is a single module.

## Test plan
- Only d_req_valid=1 at cycle 1, held 9 cycles, 8 fulfilled pulses: grant_owner=10 from cycle 2, d_req_fulfilled mirrors all 8 pulses, i_req_fulfilled stays 0, return to ST_IDLE after the drop.
- Both valid at cycle 1 after reset: dcache granted first (prio_d=1). On dcache release with icache still valid, grant_owner=01 one cycle later.
- Dcache STORE×8 then LOAD×8 with d_req_valid continuously high while icache is valid throughout: grant held for all 16 beats, no interleaving, and l2_req_type switches STORE→LOAD on the beat it changes.
- l2_req_fulfilled=1 in ST_IDLE: no fulfilled output, and protocol_error=1 from the next cycle until reset.
- Reset asserted during beat 3 of an icache grant: grant_owner=00 and l2_req_valid=0 after the edge. A pending dcache request is granted 1 cycle after reset deasserts.
- Alternating contention over 10 releases: grants strictly alternate I/D, with no requester granted twice in a row while the other is waiting.
